// File: rtl/uart_rx_stream.sv
// uart_rx_stream: receive-only UART endpoint with a ready/valid output FIFO.
// Frames are deserialised from a synchronised copy of the line. Each entry
// carries the data byte plus parity and framing error flags. A completed
// frame that finds the FIFO full is dropped and reported as an overrun.
module uart_rx_stream #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  input  logic        cr_pbit,
  input  logic        cr_ptype,
  input  logic [1:0]  cr_sbit,
  input  logic [31:0] cr_baud_limit,
  output logic [7:0]  rx_data_o,
  output logic        rx_pbit_error,
  output logic        rx_frame_error,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        rx_overrun_o,
  output logic        rx_busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   rxs;
  logic                   rxs_d;
  logic                   settled;
  logic [31:0]            cnt;
  logic [31:0]            baud_q;
  logic                   pbit_q;
  logic                   ptype_q;
  logic [1:0]             sbit_q;
  logic [2:0]             bit_idx;
  logic [1:0]             stop_idx;
  logic [1:0]             stop_last;
  logic [7:0]             shreg;
  logic                   perr;
  logic                   ferr;
  logic                   sample;
  logic                   last_stop;
  logic                   push;
  logic [9:0]             push_word;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   full;
  logic                   pop;
  logic                   push_ok;

  assign rxs       = sync_q[SYNC_STAGES-1];
  // settle_q fills with ones after reset; until it is full, rxs still shows
  // the reset value of the synchroniser rather than the real line.
  assign settled   = settle_q[SYNC_STAGES-1];
  assign sample    = (cnt == (baud_q >> 1));
  assign stop_last = (sbit_q == 2'b00) ? 2'd0 : (sbit_q == 2'b01) ? 2'd1 : 2'd2;
  assign last_stop = (stop_idx == stop_last);
  assign push      = (state == STOP) && sample && last_stop;
  assign push_word = {ferr | ~rxs, perr, shreg};

  assign full      = (count == FULL_COUNT);
  assign rx_valid_o = (count != '0);
  assign pop       = rx_valid_o & rx_ready_i;
  assign push_ok   = push & (~full | pop);

  assign rx_data_o      = mem[rd_ptr][7:0];
  assign rx_pbit_error  = mem[rd_ptr][8];
  assign rx_frame_error = mem[rd_ptr][9];

  // Bring the asynchronous line into the clock domain and keep a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '1;
      settle_q <= '0;
      rxs_d    <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      rxs_d    <= rxs;
    end
  end

  // Frame state machine: bit timing, sampling, error detection and registered busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_IDLE;
      cnt       <= '0;
      baud_q    <= '0;
      pbit_q    <= 1'b0;
      ptype_q   <= 1'b0;
      sbit_q    <= 2'b00;
      bit_idx   <= '0;
      stop_idx  <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      rx_busy_o <= 1'b0;
    end else begin
      cnt <= (cnt == baud_q - 32'd1) ? 32'd0 : cnt + 32'd1;
      case (state)
        WAIT_IDLE: begin
          if (rxs && settled) begin
            state     <= IDLE;
            rx_busy_o <= 1'b0;
          end else begin
            rx_busy_o <= 1'b1;
          end
        end
        IDLE: begin
          rx_busy_o <= 1'b0;
          if (rxs_d && !rxs) begin
            state     <= START;
            cnt       <= '0;
            baud_q    <= cr_baud_limit;
            pbit_q    <= cr_pbit;
            ptype_q   <= cr_ptype;
            sbit_q    <= cr_sbit;
            bit_idx   <= '0;
            stop_idx  <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            rx_busy_o <= 1'b1;
          end
        end
        START: begin
          if (sample) begin
            if (rxs) begin
              state     <= IDLE;
              rx_busy_o <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= pbit_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (sample) begin
            perr  <= ^{shreg, rxs, ptype_q};
            state <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            if (!rxs) begin
              ferr <= 1'b1;
            end
            stop_idx <= stop_idx + 2'd1;
            if (last_stop) begin
              if (ferr || !rxs) begin
                state <= WAIT_IDLE;
              end else begin
                state     <= IDLE;
                rx_busy_o <= 1'b0;
              end
            end
          end
        end
        default: begin
          state     <= WAIT_IDLE;
          rx_busy_o <= 1'b1;
        end
      endcase
    end
  end

  // Output FIFO: store completed frames, hand the head to the consumer, flag dropped frames
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_overrun_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rx_overrun_o <= push & full & ~pop;
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Testbench for uart_rx_stream: table of single-frame vectors plus
// hand-written sequences for break, start glitch, overrun and mid-frame reset.
module tb_uart_rx_stream;

  logic        clk;
  logic        reset;
  logic        uart_rx;
  logic        cr_pbit;
  logic        cr_ptype;
  logic [1:0]  cr_sbit;
  logic [31:0] cr_baud_limit;
  logic [7:0]  rx_data_o;
  logic        rx_pbit_error;
  logic        rx_frame_error;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        rx_overrun_o;
  logic        rx_busy_o;

  int checks;
  int fails;
  int ovr_cnt;
  logic [9:0] rx_q[$];

  typedef struct {
    int         baud;
    logic       pbit;
    logic       ptype;
    logic [1:0] sbit;
    logic [7:0] data;
    logic       par;
    logic [2:0] stop_low;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[9];

  uart_rx_stream #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .cr_pbit       (cr_pbit),
    .cr_ptype      (cr_ptype),
    .cr_sbit       (cr_sbit),
    .cr_baud_limit (cr_baud_limit),
    .rx_data_o     (rx_data_o),
    .rx_pbit_error (rx_pbit_error),
    .rx_frame_error(rx_frame_error),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .rx_overrun_o  (rx_overrun_o),
    .rx_busy_o     (rx_busy_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted head entry and every overrun pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid_o && rx_ready_i) rx_q.push_back({rx_frame_error, rx_pbit_error, rx_data_o});
      if (rx_overrun_o) ovr_cnt++;
    end
  end

  // Hang guard
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic hold_line(input logic v, input int clocks);
    uart_rx = v;
    repeat (clocks) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic par_en, input logic par,
                               input int nstop, input logic [2:0] stop_low, input int baud);
    hold_line(1'b0, baud);
    for (int b = 0; b < 8; b++) hold_line(data[b], baud);
    if (par_en) hold_line(par, baud);
    for (int s = 0; s < nstop; s++) hold_line(stop_low[s] ? 1'b0 : 1'b1, baud);
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    checkOutput(name, rx_q.size(), n);
  endtask

  task automatic check_pop(input string name, input logic [9:0] exp);
    logic [9:0] got;
    if (rx_q.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s: got no entry, expected 0x%0h", name, exp);
    end else begin
      got = rx_q.pop_front();
      checkOutput(name, {22'd0, got}, {22'd0, exp});
    end
  endtask

  task automatic set_cfg(input int baud, input logic pbit, input logic ptype, input logic [1:0] sbit);
    cr_baud_limit = baud;
    cr_pbit       = pbit;
    cr_ptype      = ptype;
    cr_sbit       = sbit;
  endtask

  function automatic int nstop_of(input logic [1:0] sbit);
    return (sbit == 2'b00) ? 1 : (sbit == 2'b01) ? 2 : 3;
  endfunction

  // Main sequence
  initial begin
    checks = 0;
    fails = 0;
    ovr_cnt = 0;
    //               baud pbit ptype sbit   data   par  stop_low exp{ferr,perr,data}
    vecs[0] = '{868, 1'b0, 1'b0, 2'b00, 8'hA5, 1'b0, 3'b000, 10'h0A5};
    vecs[1] = '{32,  1'b1, 1'b0, 2'b00, 8'h07, 1'b1, 3'b000, 10'h007};
    vecs[2] = '{32,  1'b1, 1'b0, 2'b00, 8'h07, 1'b0, 3'b000, 10'h107};
    vecs[3] = '{32,  1'b1, 1'b1, 2'b00, 8'h07, 1'b0, 3'b000, 10'h007};
    vecs[4] = '{32,  1'b1, 1'b1, 2'b00, 8'h07, 1'b1, 3'b000, 10'h107};
    vecs[5] = '{32,  1'b0, 1'b0, 2'b10, 8'h3C, 1'b0, 3'b010, 10'h23C};
    vecs[6] = '{32,  1'b0, 1'b0, 2'b01, 8'hC3, 1'b0, 3'b000, 10'h0C3};
    vecs[7] = '{32,  1'b1, 1'b0, 2'b01, 8'hFF, 1'b0, 3'b000, 10'h0FF};
    vecs[8] = '{32,  1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 3'b001, 10'h200};

    reset = 1'b1;
    uart_rx = 1'b1;
    rx_ready_i = 1'b1;
    set_cfg(32, 1'b0, 1'b0, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset valid", rx_valid_o, 0);
    checkOutput("reset data", rx_data_o, 0);
    checkOutput("reset perr", rx_pbit_error, 0);
    checkOutput("reset ferr", rx_frame_error, 0);
    checkOutput("reset overrun", rx_overrun_o, 0);
    checkOutput("reset busy", rx_busy_o, 0);
    reset = 1'b0;
    hold_line(1'b1, 10);

    for (int i = 0; i < 9; i++) begin
      set_cfg(vecs[i].baud, vecs[i].pbit, vecs[i].ptype, vecs[i].sbit);
      applyStimulus(vecs[i].data, vecs[i].pbit, vecs[i].par, nstop_of(vecs[i].sbit),
                    vecs[i].stop_low, vecs[i].baud);
      hold_line(1'b1, 2 * vecs[i].baud);
      wait_frames($sformatf("vec%0d count", i), 1, 20000);
      check_pop($sformatf("vec%0d word", i), vecs[i].exp);
    end

    // Frame error followed by a long break: only the next real frame is received
    set_cfg(32, 1'b0, 1'b0, 2'b10);
    applyStimulus(8'h3C, 1'b0, 1'b0, 3, 3'b110, 32);
    hold_line(1'b0, 20 * 32);
    hold_line(1'b1, 2 * 32);
    applyStimulus(8'h11, 1'b0, 1'b0, 3, 3'b000, 32);
    hold_line(1'b1, 2 * 32);
    wait_frames("break count", 2, 20000);
    check_pop("break ferr frame", 10'h23C);
    check_pop("break next frame", 10'h011);

    // Start glitch shorter than half a bit
    set_cfg(32, 1'b0, 1'b0, 2'b00);
    hold_line(1'b0, 8);
    checkOutput("glitch busy high", rx_busy_o, 1);
    hold_line(1'b1, 2 * 32);
    checkOutput("glitch busy low", rx_busy_o, 0);
    checkOutput("glitch no push", rx_q.size(), 0);
    applyStimulus(8'h55, 1'b0, 1'b0, 1, 3'b000, 32);
    hold_line(1'b1, 2 * 32);
    wait_frames("glitch count", 1, 20000);
    check_pop("glitch next frame", 10'h055);

    // Overrun: five back-to-back frames into a four-entry FIFO with no consumer
    rx_ready_i = 1'b0;
    ovr_cnt = 0;
    for (int f = 1; f <= 5; f++) applyStimulus(8'(f), 1'b0, 1'b0, 1, 3'b000, 32);
    hold_line(1'b1, 2 * 32);
    checkOutput("overrun pulses", ovr_cnt, 1);
    checkOutput("overrun held valid", rx_valid_o, 1);
    checkOutput("overrun held head", rx_data_o, 8'h01);
    checkOutput("overrun nothing popped", rx_q.size(), 0);
    rx_ready_i = 1'b1;
    hold_line(1'b1, 10);
    checkOutput("drain count", rx_q.size(), 4);
    for (int f = 1; f <= 4; f++) check_pop($sformatf("drain %0d", f), 10'(f));
    checkOutput("drain empty", rx_valid_o, 0);

    // Reset mid-frame with a byte waiting in the FIFO
    rx_ready_i = 1'b0;
    applyStimulus(8'h42, 1'b0, 1'b0, 1, 3'b000, 32);
    hold_line(1'b1, 2 * 32);
    checkOutput("prefill valid", rx_valid_o, 1);
    hold_line(1'b0, 32);
    hold_line(1'b1, 32);
    hold_line(1'b0, 16);
    reset = 1'b1;
    hold_line(1'b0, 3);
    checkOutput("midreset valid", rx_valid_o, 0);
    checkOutput("midreset data", rx_data_o, 0);
    checkOutput("midreset busy", rx_busy_o, 0);
    reset = 1'b0;
    rx_ready_i = 1'b1;
    hold_line(1'b0, 3 * 32);
    hold_line(1'b1, 2 * 32);
    checkOutput("postreset no output", rx_q.size(), 0);
    checkOutput("postreset valid", rx_valid_o, 0);
    applyStimulus(8'h99, 1'b0, 1'b0, 1, 3'b000, 32);
    hold_line(1'b1, 2 * 32);
    wait_frames("postreset count", 1, 20000);
    check_pop("postreset frame", 10'h099);

    hold_line(1'b1, 64);
    checkOutput("final no extra", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
Standalone UART receive endpoint that deserialises frames arriving on a serial line. It uses the same control-register fields as the combined UART core: parity enable, parity type, stop-bit count and bits-per-clock limit. Received bytes go to a consumer through a ready/valid stream with a small FIFO. It adds framing-error, parity-error and overrun reporting, and is used wherever a design or bench needs a receive-only peer with backpressure.

Parameters:
FIFO_DEPTH, 4, entries in output FIFO; power of two, >= 2
SYNC_STAGES, 2, flip-flops in uart_rx synchroniser; >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial line; idle high
cr_pbit  input  1  1 = parity bit present
cr_ptype  input  1  0 = even, 1 = odd
cr_sbit  input  2  00 = 1 stop bit, 01 = 2, 10/11 = 3
cr_baud_limit  input  32  clocks per bit period; legal range >= 4
rx_data_o  output  8  received byte at FIFO head
rx_pbit_error  output  1  parity mismatch flag of head entry
rx_frame_error  output  1  any stop bit sampled low, for head entry
rx_valid_o  output  1  FIFO non-empty
rx_ready_i  input  1  consumer accepts head when rx_valid_o & rx_ready_i
rx_overrun_o  output  1  one-clock pulse when a completed frame is dropped because the FIFO is full
rx_busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - All outputs are 0.
  - FIFO is empty.
  - Synchroniser flops are 1.
  - State is WAIT_IDLE.
- Reset mid-frame discards the partial frame. FIFO contents are lost.
- Synchroniser: SYNC_STAGES flops. All logic uses the synchronised signal (rxs) and its one-clock-delayed copy.
- Bit counter: counts 0 .. cr_baud_limit-1. A "sample point" is count == cr_baud_limit>>1.
- Config latching: cr_pbit, cr_ptype, cr_sbit and cr_baud_limit are latched at start-edge detection. Changes mid-frame have no effect until the next frame.
- State machine:
  - WAIT_IDLE: stay until rxs==1 for one clock, then go to IDLE. Prevents a line held low at reset release, or a break, from being taken as a start.
  - IDLE: a falling edge on rxs (previous 1, current 0) clears the counter and goes to START.
  - START: at the sample point, rxs==0 goes to DATA. rxs==1 is a glitch: go to IDLE, nothing pushed.
  - DATA: 8 bits, LSB first, each sampled one bit period after the previous sample point. After bit 7, go to PARITY if cr_pbit, else STOP.
  - PARITY: sample one bit.
    - Even: error if XOR(data, parity) != 0.
    - Odd: error if XOR(data, parity) != 1.
    - rx_pbit_error is always 0 for frames with cr_pbit=0.
  - STOP: sample N stop bits (N = 1/2/3 per cr_sbit). Any stop bit sampled 0 sets frame_error.
  - After the last stop-bit sample, push {frame_error, pbit_error, data}:
    - If frame_error=1, go to WAIT_IDLE.
    - Otherwise go to IDLE at once; a start edge half a bit later is caught.
- FIFO:
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the frame is dropped, rx_overrun_o pulses for 1 clock and FIFO contents are unchanged.
  - Simultaneous push and pop on an empty FIFO: the push is stored and the pop does not occur (valid was 0).
- Output: rx_valid_o rises the clock after the push. rx_data_o and both error flags are stable while rx_valid_o & !rx_ready_i.
- Latency: from last stop-bit sample point to rx_valid_o is 1 clock (FIFO empty), plus SYNC_STAGES clocks of line-to-rxs delay.
- Widths: counter is 32 bits with no overflow. A cr_baud_limit below 4 gives undefined behaviour.

Test Plan:
- 8N1 (cr_baud_limit=868, cr_pbit=0, cr_sbit=00), send 0xA5, rx_ready_i=1 -> one rx_valid_o pulse with rx_data_o=0xA5, both error flags 0.
- 8E1, send 0x07 with parity bit 1 -> data 0x07, rx_pbit_error=0. Same frame with parity bit 0 -> data 0x07, rx_pbit_error=1. Then cr_ptype=1 with parity bit 0 -> error 0.
- cr_sbit=10 (3 stop bits), send 0x3C with the 2nd stop bit driven low -> data 0x3C, rx_frame_error=1. Then hold the line low for 20 bit times, release, send 0x11 -> only 0x11 follows, no spurious frame.
- Start glitch: line low for cr_baud_limit/4 clocks then high -> no push, rx_busy_o returns to 0, a following 0x55 is received correctly.
- FIFO_DEPTH=4, rx_ready_i=0, send 0x01..0x05 back-to-back -> rx_overrun_o pulses once (at frame 5). Raising rx_ready_i drains exactly 0x01,0x02,0x03,0x04 in order.
- Assert reset mid-DATA of a frame, release while the line is low -> no output until the line goes high and a new complete frame 0x99 arrives, which is received as 0x99.
